// File: rtl/ahb_lite_pkg.sv
// AHB-Lite bus encodings and the SRAM slave state type.
// No logic: types, response codes and the byte-lane helper only.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } slave_state_t;

    // Lanes stay at their bus positions: a byte at offset 3 uses lane 3.
    function automatic logic [3:0] byte_en(input hsize_t size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return 4'b0011 << lane;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_byte_mem.sv
// Word-wide SRAM array with per-byte write enables; one write and one read port.
// Latency: read data registered one cycle after rd_en; no backpressure, no reset.
module ahb_sram_byte_mem #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  HCLK,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-3:0] wr_addr,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-3:0] rd_addr,
    output logic [31:0]           rd_dat
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit the same word.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte/half/word access, any burst, two-cycle ERROR on illegal access.
// Latency: WAIT_STATES low cycles per OKAY data phase; stalls the bus only via HREADYOUT.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 8,
    parameter int         WAIT_STATES = 0,
    parameter logic [1:0] SLAVE_ID    = 2'b01
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [1:0]  HSELx_slaves,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_t          state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    hsize_t                size_q;

    logic                  accept, legal, start;
    logic                  rd_from_bus, rd_en, wr_en, fwd_hit;
    logic [ADDR_WIDTH-3:0] rd_addr;
    logic [3:0]            wr_be;
    logic [31:0]           mem_rd_dat;
    logic                  rd_vld_q;
    logic [3:0]            fwd_be_q;
    logic [31:0]           fwd_dat_q;

    // Every beat is self-addressed, so the burst type and decoder bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:30]};

    assign accept = HREADY && (HSELx_slaves == SLAVE_ID) &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_comb begin
        legal = 1'b1;
        if (HSIZE > 3'b010)                          legal = 1'b0;
        if (HSIZE == 3'b001 && HADDR[0])             legal = 1'b0;
        if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)  legal = 1'b0;
        if (HADDR[29:ADDR_WIDTH] != '0)              legal = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        start     = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            IDLE, DATA, ERR2: begin
                if (state_q == ERR2) HRESP = HRESP_ERROR;
                state_d = IDLE;
                if (accept) begin
                    start = 1'b1;
                    if (!legal) begin
                        state_d = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = WAIT_INIT;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            WAIT: begin
                HREADYOUT = 1'b0;
                if (wcnt_q == 4'd0) state_d = DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ERR2;
            end
            default: state_d = IDLE;
        endcase
    end

    // The read is launched on the cycle before DATA: straight off the bus with no
    // wait states, otherwise from the registered offset at the end of WAIT.
    assign rd_from_bus = (state_q != WAIT);
    assign rd_addr     = rd_from_bus ? HADDR[ADDR_WIDTH-1:2] : addr_q[ADDR_WIDTH-1:2];
    assign rd_en       = (state_d == DATA) && (rd_from_bus ? !HWRITE : !write_q);

    assign wr_en   = (state_q == DATA) && write_q && HRESETn;
    assign wr_be   = byte_en(size_q, addr_q[1:0]);
    assign fwd_hit = wr_en && rd_en && (rd_addr == addr_q[ADDR_WIDTH-1:2]);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= HSIZE_BYTE;
            rd_vld_q  <= 1'b0;
            fwd_be_q  <= '0;
            fwd_dat_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (start) begin
                addr_q  <= HADDR[ADDR_WIDTH-1:0];
                write_q <= HWRITE;
                size_q  <= hsize_t'(HSIZE);
            end
            if (rd_en) begin
                rd_vld_q  <= 1'b1;
                fwd_be_q  <= fwd_hit ? wr_be : 4'b0000;
                fwd_dat_q <= HWDATA;
            end
        end
    end

    ahb_sram_byte_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .HCLK    (HCLK),
        .wr_en   (wr_en),
        .wr_addr (addr_q[ADDR_WIDTH-1:2]),
        .wr_be   (wr_be),
        .wr_dat  (HWDATA),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_dat  (mem_rd_dat)
    );

    // Bytes being written in the same cycle as the read override the stale array word.
    always_comb begin
        HRDATA = '0;
        if (rd_vld_q) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = fwd_be_q[i] ? fwd_dat_q[8*i +: 8] : mem_rd_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Two slaves (0 and 2 wait states) on one bus with a modelled decoder/response mux,
// checked against a byte-addressed reference memory.
module tb_ahb_lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HSELx_slaves;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        rdy0, rdy2, resp0, resp2;
    logic [31:0] rdata0, rdata2;
    logic [1:0]  dp_owner;

    always #5 HCLK = ~HCLK;

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .WAIT_STATES(0), .SLAVE_ID(2'b01)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HSELx_slaves(HSELx_slaves), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HREADY(HREADY), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .WAIT_STATES(2), .SLAVE_ID(2'b10)) u_ws2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HSELx_slaves(HSELx_slaves), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HREADY(HREADY), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2)
    );

    // Response mux follows whichever slave owns the current data phase.
    always @(posedge HCLK) begin
        if (!HRESETn)    dp_owner <= 2'b00;
        else if (HREADY) dp_owner <= HSELx_slaves;
    end
    assign HREADY = (dp_owner == 2'b01) ? rdy0  : (dp_owner == 2'b10) ? rdy2  : 1'b1;
    assign HRESP  = (dp_owner == 2'b01) ? resp0 : (dp_owner == 2'b10) ? resp2 : 1'b0;
    assign HRDATA = (dp_owner == 2'b01) ? rdata0 : (dp_owner == 2'b10) ? rdata2 : 32'h0;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] res_rdata[$];
    int          res_nw[$];
    logic [7:0]  mdl [2][256];
    int          errors = 0;
    int          checks = 0;
    int          xidx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [2:0] burst,
                        input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size;
        x.burst = burst; x.addr = addr; x.wdata = wdata;
        q.push_back(x);
    endtask

    // Reference: a selected NONSEQ/SEQ is legal if naturally aligned, size <= word and inside 256 bytes.
    task automatic check_prev(input xfer_t x, input int nw, input logic rf, input logic rl,
                              input logic [31:0] rd);
        int    u, off, w, exp_nw;
        bit    sel_ok, legal;
        logic  exp_rf, exp_rl;
        logic [31:0] exp_w;
        sel_ok = (x.sel == 2'b01 || x.sel == 2'b10) && x.trans[1];
        off    = int'(x.addr[29:0]);
        legal  = (x.size <= 3'd2) && ((off % (1 << x.size)) == 0) && (off < 256);
        u      = (x.sel == 2'b10) ? 1 : 0;
        exp_nw = 0; exp_rf = 1'b0; exp_rl = 1'b0;
        if (sel_ok && !legal) begin
            exp_nw = 1; exp_rf = 1'b1; exp_rl = 1'b1;
        end else if (sel_ok) begin
            exp_nw = (u == 1) ? 2 : 0;
            if (x.wr) begin
                for (int b = 0; b < (1 << x.size); b++)
                    mdl[u][off + b] = x.wdata[8*((off + b) % 4) +: 8];
            end else begin
                w = off - (off % 4);
                exp_w = {mdl[u][w+3], mdl[u][w+2], mdl[u][w+1], mdl[u][w]};
                check($sformatf("x%0d.rdata", xidx), rd, exp_w);
            end
        end
        check($sformatf("x%0d.waits", xidx), 32'(nw), 32'(exp_nw));
        check($sformatf("x%0d.resp_first", xidx), {31'b0, rf}, {31'b0, exp_rf});
        check($sformatf("x%0d.resp_last", xidx), {31'b0, rl}, {31'b0, exp_rl});
        xidx++;
    endtask

    // Drives the queued transfers as a pipeline; entered and left at posedge+1.
    task automatic run_seq(input bit scramble);
        xfer_t cur, prev;
        bit    have_prev;
        int    n, nw;
        logic  rf, rl;
        logic [31:0] rd;
        have_prev = 0;
        n = q.size();
        res_rdata.delete();
        res_nw.delete();
        for (int k = 0; k <= n; k++) begin
            if (k < n) cur = q[k];
            else begin
                cur.sel = 2'b00; cur.trans = 2'b00; cur.wr = 1'b0; cur.size = 3'd0;
                cur.burst = 3'd0; cur.addr = 32'h0; cur.wdata = 32'h0;
            end
            HSELx_slaves = cur.sel; HTRANS = cur.trans; HWRITE = cur.wr;
            HSIZE = cur.size; HBURST = cur.burst; HADDR = cur.addr;
            HWDATA = have_prev ? prev.wdata : $urandom;
            nw = 0; rf = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge HCLK);
                if (c == 0) rf = HRESP;
                if (HREADY) break;
                nw++;
                @(posedge HCLK); #1;
                if (scramble && k == n) HADDR = $urandom;
            end
            rl = HRESP;
            rd = HRDATA;
            if (have_prev) begin
                check_prev(prev, nw, rf, rl, rd);
                res_rdata.push_back(rd);
                res_nw.push_back(nw);
            end
            @(posedge HCLK); #1;
            prev = cur;
            have_prev = 1;
        end
        q.delete();
    endtask

    initial begin
        logic [1:0]  sel, trans;
        logic [2:0]  size;
        logic [31:0] addr;
        int          lane;

        HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HSELx_slaves = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'd0; HTRANS = 2'b00; HBURST = 3'd0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready0", {31'b0, rdy0}, 32'd1);
        check("rst_resp0", {31'b0, resp0}, 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ready2", {31'b0, rdy2}, 32'd1);
        check("rst_resp2", {31'b0, resp2}, 32'd0);
        check("rst_rdata2", rdata2, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        for (int w = 0; w < 64; w++) begin
            push(2'b01, 2'b10, 1'b1, 3'd2, 3'd0, 32'(4 * w), $urandom);
            push(2'b10, 2'b10, 1'b1, 3'd2, 3'd0, 32'(4 * w), $urandom);
        end
        run_seq(0);

        push(2'b01, 2'b10, 1'b1, 3'd2, 3'd0, 32'h10, 32'hDEADBEEF);
        push(2'b01, 2'b10, 1'b0, 3'd2, 3'd0, 32'h10, 32'h0);
        run_seq(0);
        check("t1_fwd_rdata", res_rdata[1], 32'hDEADBEEF);
        check("t1_fwd_waits", 32'(res_nw[1]), 32'd0);

        push(2'b01, 2'b10, 1'b1, 3'd2, 3'd0, 32'h10, 32'h11223344);
        push(2'b01, 2'b10, 1'b1, 3'd0, 3'd0, 32'h13, 32'hAA000000);
        push(2'b01, 2'b10, 1'b0, 3'd2, 3'd0, 32'h10, 32'h0);
        push(2'b01, 2'b10, 1'b1, 3'd1, 3'd0, 32'h12, 32'h55660000);
        push(2'b01, 2'b10, 1'b0, 3'd2, 3'd0, 32'h10, 32'h0);
        run_seq(0);
        check("t2_byte_merge", res_rdata[2], 32'hAA223344);
        check("t2_half_merge", res_rdata[4], 32'h55663344);

        push(2'b10, 2'b10, 1'b1, 3'd2, 3'd0, 32'h10, 32'hA5A51234);
        push(2'b10, 2'b10, 1'b0, 3'd2, 3'd0, 32'h10, 32'h0);
        run_seq(1);
        check("t3_ws_rdata", res_rdata[1], 32'hA5A51234);
        check("t3_ws_waits", 32'(res_nw[1]), 32'd2);

        for (int s = 1; s <= 2; s++) begin
            sel = 2'(s);
            push(sel, 2'b10, 1'b1, 3'd2, 3'd0, 32'h02, $urandom);
            push(sel, 2'b10, 1'b1, 3'd3, 3'd0, 32'h00, $urandom);
            push(sel, 2'b10, 1'b1, 3'd2, 3'd0, 32'h100, $urandom);
            push(sel, 2'b10, 1'b0, 3'd2, 3'd0, 32'h00, 32'h0);
            push(sel, 2'b10, 1'b0, 3'd2, 3'd0, 32'h100, 32'h0);
            run_seq(0);
        end

        for (int s = 1; s <= 2; s++) begin
            sel = 2'(s);
            push(sel, 2'b10, 1'b1, 3'd2, 3'b011, 32'h20, 32'd1);
            push(sel, 2'b11, 1'b1, 3'd2, 3'b011, 32'h24, 32'd2);
            push(sel, 2'b01, 1'b1, 3'd2, 3'b011, 32'h28, 32'd3);
            push(sel, 2'b11, 1'b1, 3'd2, 3'b011, 32'h28, 32'd3);
            push(sel, 2'b11, 1'b1, 3'd2, 3'b011, 32'h2C, 32'd4);
            push(sel, 2'b10, 1'b0, 3'd2, 3'b010, 32'h28, 32'h0);
            push(sel, 2'b11, 1'b0, 3'd2, 3'b010, 32'h2C, 32'h0);
            push(sel, 2'b11, 1'b0, 3'd2, 3'b010, 32'h20, 32'h0);
            push(sel, 2'b11, 1'b0, 3'd2, 3'b010, 32'h24, 32'h0);
            run_seq(0);
            check($sformatf("t5_busy_waits_s%0d", s), 32'(res_nw[2]), 32'd0);
            check($sformatf("t5_wrap0_s%0d", s), res_rdata[5], 32'd3);
            check($sformatf("t5_wrap1_s%0d", s), res_rdata[6], 32'd4);
            check($sformatf("t5_wrap2_s%0d", s), res_rdata[7], 32'd1);
            check($sformatf("t5_wrap3_s%0d", s), res_rdata[8], 32'd2);
        end

        // Reset lands in the second wait cycle of a write; the write must vanish.
        HSELx_slaves = 2'b10; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HWDATA = 32'hCAFEF00D;
        @(negedge HCLK);
        check("t6_in_wait", {31'b0, rdy2}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("t6_ready2", {31'b0, rdy2}, 32'd1);
        check("t6_resp2", {31'b0, resp2}, 32'd0);
        check("t6_rdata2", rdata2, 32'h0);
        check("t6_rdata0", rdata0, 32'h0);
        @(posedge HCLK); #1;
        push(2'b10, 2'b10, 1'b0, 3'd2, 3'd0, 32'h40, 32'h0);
        run_seq(0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    sel = 2'b01;
                2, 3:    sel = 2'b10;
                4:       sel = 2'b00;
                default: sel = 2'b11;
            endcase
            case ($urandom_range(0, 7))
                0:          trans = 2'b00;
                1:          trans = 2'b01;
                2, 3, 4:    trans = 2'b10;
                default:    trans = 2'b11;
            endcase
            size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) lane = $urandom_range(0, 3);
            else if (size == 3'd0)          lane = $urandom_range(0, 3);
            else if (size == 3'd1)          lane = 2 * $urandom_range(0, 1);
            else                            lane = 0;
            addr = 32'h80 + 32'(4 * $urandom_range(0, 3)) + 32'(lane);
            if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << (8 + $urandom_range(0, 21)));
            addr[31:30] = 2'($urandom_range(0, 3));
            push(sel, trans, 1'($urandom_range(0, 1)), size, 3'($urandom_range(0, 7)), addr, $urandom);
        end
        run_seq(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- Second-generation AHB-Lite memory slave; replaces the fixed 64-byte, SINGLE/INCR-only slaves.
- Word-organised SRAM with little-endian byte lanes; accepts every HBURST type; configurable wait states.
- Returns a two-cycle ERROR response on illegal accesses; forwards write data to a back-to-back read of the same word.
- Sits behind the address decoder and feeds the response mux, alongside the existing slaves.

Parameters:
- ADDR_WIDTH, 8, byte-offset bits implemented; memory = 2**ADDR_WIDTH bytes, 2**(ADDR_WIDTH-2) words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted at the start of each OKAY data phase (0..15).
- SLAVE_ID, 2'b01, HSELx_slaves code that selects this slave.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  32  address; HADDR[29:0] is the slave offset.
- HWDATA  in  32  write data, valid in data phase.
- HSELx_slaves  in  2  decoder select code.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 = byte, 001 = half, 010 = word; others illegal.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HBURST  in  3  accepted and ignored; every beat is addressed by HADDR.
- HREADY  in  1  bus ready, from the mux.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset values: HRESETn low at a rising edge gives state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
- Reset mid-transfer discards any pending write. Memory contents are not reset.
- Address phase accepted when HREADY && HSELx_slaves==SLAVE_ID && HTRANS[1]. The slave registers offset, HWRITE and HSIZE.
- A transfer is illegal if any of these holds:
  - HSIZE > 010;
  - misaligned: half with HADDR[0]=1, or word with HADDR[1:0]!=00;
  - HADDR[29:ADDR_WIDTH] != 0.
- Illegal transfers cause no memory access.
- IDLE or BUSY transfers, or not selected: no access. If in state IDLE, HREADYOUT=1 and HRESP=0.
- State machine states: IDLE, WAIT, DATA, ERR1, ERR2.
  - Legal transfer accepted: go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else DATA.
  - Illegal transfer accepted: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; decrement counter; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. Next state is decided by the same acceptance rule as IDLE (pipelined back-to-back), otherwise IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state by the acceptance rule, otherwise IDLE. A master that cancels with IDLE goes to IDLE.
- Write: byte enables come from the registered size and offset[1:0]:
  - byte: 1 << a[1:0];
  - half: 0011 << a[1:0];
  - word: 1111.
  - Lanes are taken from HWDATA at the same lane positions (AHB lane rule, not shifted down).
  - Memory is updated on the rising edge ending the DATA cycle.
- Read: memory word read synchronously from the registered offset. HRDATA is loaded on the last cycle before DATA and held through DATA.
  - Full word returned on all lanes; the master selects lanes.
  - HRDATA holds its last value outside read DATA.
- Forwarding: a read whose DATA cycle follows a write DATA cycle to the same word returns the merged word. Bytes come from the write where its enable is set, otherwise from memory. Zero-wait-state back-to-back reads never see stale data.
- Wait states: with HREADY low and not selected, no address is captured. Registered fields hold during WAIT.

Decomposition:
- Package ahb_lite_pkg holds:
  - htrans_t enum;
  - hsize_t enum;
  - hburst_t enum;
  - HRESP_OKAY and HRESP_ERROR constants;
  - slave_state_t enum (IDLE, WAIT, DATA, ERR1, ERR2).
- Sub-module ahb_sram_byte_mem:
  - 2**(ADDR_WIDTH-2) x 32 array;
  - 4-bit byte-enable synchronous write;
  - synchronous read, one port each;
  - no reset.

Test Plan:
- WAIT_STATES=0. Word write 0xDEADBEEF at offset 0x10, then word read at 0x10 in the next address phase → HRDATA=0xDEADBEEF in the read DATA cycle (forwarded), HREADYOUT stays 1.
- Byte write 0xAA at 0x13 (HWDATA=0xAA000000) over the word 0x11223344 → read of 0x10 returns 0xAA223344. Half write 0x5566 at 0x12 (HWDATA=0x55660000) gives 0x55663344.
- WAIT_STATES=2. Single read → HREADYOUT pattern 0,0,1 in the data phase; HRDATA valid on the third cycle; HADDR changes during the wait do not alter the result.
- Word access at 0x02, HSIZE=011 at 0x00, and offset 0x100 with ADDR_WIDTH=8 → each gives HREADYOUT/HRESP = 0/1 then 1/1; memory unchanged on readback.
- INCR4 word writes to 0x20-0x2C (data 1, 2, 3, 4), a BUSY inserted between beats 2 and 3 → BUSY gets a zero-wait OKAY; a WRAP4 read from 0x28 returns 3, 4, 1, 2.
- Assert HRESETn=0 during the WAIT of a write → write lost (old data read back), outputs at reset values; the next transfer after release completes normally.
